// File: rtl/bitty_sequencer_if.sv
// Sequencer <-> instruction memory / control unit bundle.
// master: sequencer side; slave: memory + CU side.
interface bitty_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata;
  logic [15:0]       instruction;
  logic              en_i;
  logic              en_s;
  logic              en_c;
  logic              cu_done;

  modport master (
    output imem_addr,
    output instruction,
    output en_i,
    output en_s,
    output en_c,
    input  imem_rdata,
    input  cu_done
  );

  modport slave (
    input  imem_addr,
    input  instruction,
    input  en_i,
    input  en_s,
    input  en_c,
    output imem_rdata,
    output cu_done
  );
endinterface

// File: rtl/bitty_sequencer.sv
// Program sequencer for the bitty CU: fetches words from a synchronous
// imem and runs the en_i/en_s/en_c/cu_done handshake per instruction.
// Ports: clk, reset (async, high), start, prog_len, halt_req,
//   bus (imem_addr/imem_rdata, instruction, en_i/en_s/en_c, cu_done),
//   busy, prog_done, error, pc, retired.
module bitty_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W:0]      prog_len,
  input  logic                 halt_req,
  bitty_sequencer_if.master    bus,
  output logic                 busy,
  output logic                 prog_done,
  output logic                 error,
  output logic [ADDR_W-1:0]    pc,
  output logic [15:0]          retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_EN_S   = 3'd3;
  localparam logic [2:0] S_EN_C   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_RETIRE = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [2:0]      state;
  logic [15:0]     instr_q;
  logic [ADDR_W:0] len_q;
  logic [WD_W-1:0] wdog;
  logic            halt_q;
  logic            error_q;
  logic            zdone_q;
  logic            last;
  logic            spurious;
  logic            finish;

  // Extended by one bit so prog_len = 2**ADDR_W terminates as pc wraps.
  assign last = (({1'b0, pc} + (ADDR_W+1)'(1)) == len_q);

  // cu_done outside S_WAIT means the CU and sequencer lost sync.
  assign spurious = bus.cu_done
                  && (state != S_IDLE)
                  && (state != S_WAIT)
                  && (state != S_ERROR);

  assign finish = (state == S_RETIRE) && !bus.cu_done && (last || halt_q);

  assign busy      = (state != S_IDLE);
  assign error     = error_q;
  // Zero-length programs pulse from a register; normal ends pulse in RETIRE.
  assign prog_done = zdone_q | finish;

  assign bus.imem_addr   = pc;
  assign bus.en_i        = (state == S_ISSUE);
  assign bus.en_s        = (state == S_EN_S);
  assign bus.en_c        = (state == S_EN_C);
  assign bus.instruction = (state == S_ISSUE) ? bus.imem_rdata : instr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      retired <= '0;
      instr_q <= '0;
      len_q   <= '0;
      wdog    <= '0;
      halt_q  <= 1'b0;
      error_q <= 1'b0;
      zdone_q <= 1'b0;
    end else begin
      zdone_q <= 1'b0;
      if (busy) halt_q <= halt_q | halt_req;
      if (spurious) begin
        state   <= S_ERROR;
        error_q <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              len_q   <= prog_len;
              pc      <= '0;
              retired <= '0;
              error_q <= 1'b0;
              if (prog_len == '0) zdone_q <= 1'b1;
              else                state   <= S_FETCH;
            end
          end
          S_FETCH: state <= S_ISSUE;
          S_ISSUE: begin
            instr_q <= bus.imem_rdata;
            state   <= S_EN_S;
          end
          S_EN_S: state <= S_EN_C;
          S_EN_C: begin
            wdog  <= '0;
            state <= S_WAIT;
          end
          S_WAIT: begin
            wdog <= wdog + WD_W'(1);
            if (bus.cu_done) begin
              state <= S_RETIRE;
            end else if (wdog == WD_W'(TIMEOUT - 1)) begin
              state   <= S_ERROR;
              error_q <= 1'b1;
            end
          end
          S_RETIRE: begin
            pc      <= pc + ADDR_W'(1);
            retired <= retired + 16'd1;
            if (last || halt_q) begin
              state  <= S_IDLE;
              halt_q <= 1'b0;
            end else begin
              state <= S_FETCH;
            end
          end
          S_ERROR: state <= S_ERROR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bitty_sequencer.sv
// Self-checking bench for bitty_sequencer with imem and CU models.
// Ports: none (top-level bench).
module tb_bitty_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  prog_len;
  logic        halt_req;
  logic        busy;
  logic        prog_done;
  logic        error;
  logic [7:0]  pc;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [256];
  logic [2:0]  cu_st;
  logic        cu_stall;
  logic        force_done;

  bitty_sequencer_if #(.ADDR_W(8)) bus ();

  bitty_sequencer #(.ADDR_W(8), .TIMEOUT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .prog_len  (prog_len),
    .halt_req  (halt_req),
    .bus       (bus),
    .busy      (busy),
    .prog_done (prog_done),
    .error     (error),
    .pc        (pc),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

  // CU model: IDLE -> LOAD -> CALC -> STORE -> DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cu_st <= 3'd0;
    else begin
      case (cu_st)
        3'd0: if (bus.en_i) cu_st <= 3'd1;
        3'd1: if (bus.en_s) cu_st <= 3'd2;
        3'd2: if (bus.en_c) cu_st <= 3'd3;
        3'd3: cu_st <= 3'd4;
        3'd4: cu_st <= cu_stall ? 3'd4 : 3'd0;
        default: cu_st <= 3'd0;
      endcase
    end
  end

  assign bus.cu_done = ((cu_st == 3'd4) && !cu_stall) || force_done;

  typedef struct {
    logic [8:0] len;
    int         halt_cyc;
    int         exp_cyc;
    int         exp_ret;
    int         exp_pc;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int done_cyc;
    int n_eni;
    done_cyc = -1;
    n_eni = 0;
    @(negedge clk);
    start = 1'b1;
    prog_len = v.len;
    for (int k = 1; k <= v.exp_cyc + 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      halt_req = (k == v.halt_cyc);
      if (k == v.halt_cyc) chk("halt_in_en_s", 32'(bus.en_s), 1);
      if (bus.en_i) begin
        chk("en_i_cycle", k, 2 + 7 * n_eni);
        chk("instr", 32'(bus.instruction), 32'(mem[n_eni & 255]));
        n_eni++;
      end
      if (prog_done) begin
        done_cyc = k;
        break;
      end
    end
    halt_req = 1'b0;
    chk("done_cycle", done_cyc, v.exp_cyc);
    chk("en_i_count", n_eni, v.exp_ret);
    @(negedge clk);
    chk("retired", 32'(retired), v.exp_ret);
    chk("pc", 32'(pc), v.exp_pc);
    chk("error_clr", 32'(error), 0);
    chk("busy_end", 32'(busy), 0);
    chk("done_pulse", 32'(prog_done), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end

  initial begin
    mem[0] = 16'h0A41;
    mem[1] = 16'h2B52;
    mem[2] = 16'h4C63;
    for (int i = 3; i < 256; i++) mem[i] = 16'(16'h1000 + i * 263);

    vt[0] = '{9'd3,   0, 21,   3,   3};
    vt[1] = '{9'd1,   0, 7,    1,   1};
    vt[2] = '{9'd5,   10, 14,  2,   2};
    vt[3] = '{9'd4,   0, 28,   4,   4};
    vt[4] = '{9'd256, 0, 1792, 256, 0};

    reset = 1'b1;
    start = 1'b0;
    prog_len = '0;
    halt_req = 1'b0;
    cu_stall = 1'b0;
    force_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_done", 32'(prog_done), 0);
    chk("rst_en", 32'({bus.en_i, bus.en_s, bus.en_c}), 0);
    chk("rst_instr", 32'(bus.instruction), 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // zero-length program
    @(negedge clk);
    start = 1'b1;
    prog_len = 9'd0;
    chk("zero_done_early", 32'(prog_done), 0);
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", 32'(prog_done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_retired", 32'(retired), 0);
    @(negedge clk);
    chk("zero_done_off", 32'(prog_done), 0);
    chk("zero_busy2", 32'(busy), 0);

    // watchdog expiry
    cu_stall = 1'b1;
    @(negedge clk);
    start = 1'b1;
    prog_len = 9'd2;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 4)  chk("wd_en_c", 32'(bus.en_c), 1);
      if (k == 12) chk("wd_err_early", 32'(error), 0);
      if (k == 13) begin
        chk("wd_error", 32'(error), 1);
        chk("wd_busy", 32'(busy), 1);
      end
    end
    start = 1'b1;
    prog_len = 9'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("err_start_ign", 32'(error), 1);
    chk("err_busy", 32'(busy), 1);
    chk("err_no_en_i", 32'(bus.en_i), 0);
    reset = 1'b1;
    #1;
    chk("err_rst_error", 32'(error), 0);
    chk("err_rst_busy", 32'(busy), 0);
    chk("err_rst_pc", 32'(pc), 0);
    @(negedge clk);
    reset = 1'b0;
    cu_stall = 1'b0;

    // spurious cu_done in S_EN_S of instruction 2
    @(negedge clk);
    start = 1'b1;
    prog_len = 9'd3;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) begin
        chk("sp_en_s", 32'(bus.en_s), 1);
        force_done = 1'b1;
      end
      if (k == 11) begin
        force_done = 1'b0;
        chk("sp_error", 32'(error), 1);
        chk("sp_busy", 32'(busy), 1);
        chk("sp_en_c", 32'(bus.en_c), 0);
      end
    end
    @(negedge clk);
    chk("sp_retired", 32'(retired), 1);
    chk("sp_pc", 32'(pc), 1);
    pulse_reset();

    // async reset in S_WAIT of instruction 2
    @(negedge clk);
    start = 1'b1;
    prog_len = 9'd3;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("ar_pre_retired", 32'(retired), 1);
    reset = 1'b1;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_pc", 32'(pc), 0);
    chk("ar_retired", 32'(retired), 0);
    chk("ar_instr", 32'(bus.instruction), 0);
    chk("ar_en", 32'({bus.en_i, bus.en_s, bus.en_c}), 0);
    @(negedge clk);
    reset = 1'b0;
    run_vec('{9'd2, 0, 14, 2, 2});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
